// File: rtl/periph_pkg.sv
// Shared definitions for the peripheral store controller.
//   - default store addresses for the GPIO, UART and status-clear registers
//   - target_e: peripheral selected by the most recent address phase
//   - drain_e:  states of the UART FIFO drain FSM
//   - decode_target(): full 32-bit address to target decode
package periph_pkg;

  localparam logic [31:0] DEF_GPIO_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEF_UART_ADDR = 32'h1000_0100;
  localparam logic [31:0] DEF_STAT_ADDR = 32'h1000_0104;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_GPIO = 2'd1,
    TGT_UART = 2'd2,
    TGT_STAT = 2'd3
  } target_e;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_START = 2'd1,
    D_WAIT  = 2'd2
  } drain_e;

  function automatic target_e decode_target(
    input logic [31:0] addr,
    input logic [31:0] gpio_addr,
    input logic [31:0] uart_addr,
    input logic [31:0] stat_addr
  );
    if (addr == gpio_addr)      return TGT_GPIO;
    else if (addr == uart_addr) return TGT_UART;
    else if (addr == stat_addr) return TGT_STAT;
    else                        return TGT_NONE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-wrap-bit pointers.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset (clears pointers)
//   i_push, i_wdata    write request and data (ignored when full)
//   i_pop              read request (ignored when empty)
//   o_rdata            head entry, valid while not empty
//   o_full, o_empty    occupancy flags
//   o_count            number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/periph_store_ctrl.sv
// Memory-mapped store decoder for GPIO, UART transmit FIFO and status clear,
// plus the FSM that drains the FIFO into a byte-wide UART transmitter.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   data_out          CPU store bus (address in addr phase, data in data phase)
//   store_addr_out    address-phase strobe
//   store_data_out    data-phase strobe
//   uart_busy         UART transmitter shifting a byte
//   uart_tx_en        one-cycle start pulse to the UART
//   uart_tx_data      byte handed to the UART, held until the next pop
//   gpio_out          GPIO output register
//   fifo_count        UART FIFO occupancy
//   overflow          sticky: a UART byte was dropped on a full FIFO
//
// Drain FSM
//   state   | meaning
//   D_IDLE  | waiting for a queued byte and an idle UART; pops on entry to D_START
//   D_START | start pulse just issued; one cycle for uart_busy to rise
//   D_WAIT  | UART shifting; leave on first cycle uart_busy is low
module periph_store_ctrl
  import periph_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] GPIO_ADDR  = DEF_GPIO_ADDR,
  parameter logic [31:0] UART_ADDR  = DEF_UART_ADDR,
  parameter logic [31:0] STAT_ADDR  = DEF_STAT_ADDR
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 data_out,
  input  logic                        store_addr_out,
  input  logic                        store_data_out,
  input  logic                        uart_busy,
  output logic                        uart_tx_en,
  output logic [7:0]                  uart_tx_data,
  output logic [7:0]                  gpio_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  target_e    r_target;
  drain_e     r_dstate;
  drain_e     w_dstate_nxt;
  logic [7:0] r_gpio;
  logic       r_overflow;
  logic       r_tx_en;
  logic [7:0] r_tx_data;

  logic       w_uart_store;
  logic       w_push;
  logic       w_drop;
  logic       w_clr;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_rd_data;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  // Fullness is judged before any same-cycle pop, so a store into a full
  // FIFO is dropped even when the drain frees a slot on that edge.
  assign w_uart_store = store_data_out && (r_target == TGT_UART);
  assign w_push       = w_uart_store && !w_full;
  assign w_drop       = w_uart_store && w_full;
  assign w_clr        = store_data_out && (r_target == TGT_STAT) && data_out[0];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (data_out[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_rd_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Data applies to the previously latched target; a coincident address
  // phase then replaces the cleared target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_target   <= TGT_NONE;
      r_gpio     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (store_addr_out)
        r_target <= decode_target(data_out, GPIO_ADDR, UART_ADDR, STAT_ADDR);
      else if (store_data_out)
        r_target <= TGT_NONE;

      if (store_data_out && (r_target == TGT_GPIO))
        r_gpio <= data_out[7:0];

      // A drop wins over a same-cycle clear.
      if (w_drop)
        r_overflow <= 1'b1;
      else if (w_clr)
        r_overflow <= 1'b0;
    end
  end

  always_comb begin
    w_dstate_nxt = r_dstate;
    w_pop        = 1'b0;
    case (r_dstate)
      D_IDLE: begin
        if (!w_empty && !uart_busy) begin
          w_pop        = 1'b1;
          w_dstate_nxt = D_START;
        end
      end
      D_START: w_dstate_nxt = D_WAIT;
      D_WAIT: begin
        if (!uart_busy) w_dstate_nxt = D_IDLE;
      end
      default: w_dstate_nxt = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dstate  <= D_IDLE;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_dstate <= w_dstate_nxt;
      r_tx_en  <= w_pop;
      if (w_pop) r_tx_data <= w_rd_data;
    end
  end

  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;
  assign gpio_out     = r_gpio;
  assign fifo_count   = w_count;
  assign overflow     = r_overflow;

endmodule
